// File: rtl/bm_if_arbiter_pkg.sv
// bm_if_arbiter_pkg: shared operand width, FSM state and opcode encodings
package bm_if_arbiter_pkg;
    localparam int DEF_BITS = 2;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SERVE0 = 2'b01,
        SERVE1 = 2'b10
    } state_t;
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_DEC = 2'b11;
endpackage

// File: rtl/bm_if_op_unit.sv
// bm_if_op_unit: registered logic op unit; result only updates on a transfer
module bm_if_op_unit
    import bm_if_arbiter_pkg::*;
#(
    parameter int BITS = DEF_BITS
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_en,
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    input  logic [1:0]      i_op,
    output logic [BITS-1:0] o_result
);
    logic [BITS-1:0] w_res;
    logic [BITS-1:0] r_result;
    always_comb begin
        w_res = '0;
        case (i_op)
            OP_AND: w_res = i_a & i_b;
            OP_OR:  w_res = i_a | i_b;
            OP_XOR: w_res = i_a ^ i_b;
            OP_DEC: if (i_a == '0) w_res = '1; else w_res = ~i_a;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) r_result <= '0;
        else if (i_en) r_result <= w_res;
    end
    assign o_result = r_result;
endmodule

// File: rtl/bm_if_arbiter.sv
// bm_if_arbiter: two-requester round-robin arbiter with hold cap in front of
// a registered op unit; results come back one cycle later tagged with owner.
module bm_if_arbiter
    import bm_if_arbiter_pkg::*;
#(
    parameter int BITS     = DEF_BITS,
    parameter int HOLD_MAX = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req0,
    input  logic            req1,
    input  logic [BITS-1:0] a0,
    input  logic [BITS-1:0] b0,
    input  logic [BITS-1:0] a1,
    input  logic [BITS-1:0] b1,
    input  logic [1:0]      op0,
    input  logic [1:0]      op1,
    output logic            gnt0,
    output logic            gnt1,
    output logic [BITS-1:0] result,
    output logic            valid,
    output logic            owner,
    output logic            busy
);
    localparam logic [2:0] HOLD_TOP = 3'(HOLD_MAX - 1);
    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_hold;
    logic            r_last;
    logic            r_valid;
    logic            r_owner;
    logic            w_xfer0;
    logic            w_xfer1;
    logic            w_xfer;
    logic            w_cap;
    logic            w_enter;
    logic [BITS-1:0] w_a;
    logic [BITS-1:0] w_b;
    logic [1:0]      w_op;
    assign gnt0    = r_state == SERVE0;
    assign gnt1    = r_state == SERVE1;
    assign busy    = r_state != IDLE;
    assign w_xfer0 = gnt0 && req0;
    assign w_xfer1 = gnt1 && req1;
    assign w_xfer  = w_xfer0 || w_xfer1;
    assign w_cap   = r_hold == HOLD_TOP;
    // The illegal encoding 2'b11 falls through to the IDLE arbitration.
    assign w_next = gnt0 ? (((!req0 || w_cap) && req1) ? SERVE1 : req0 ? SERVE0 : IDLE) :
                    gnt1 ? (((!req1 || w_cap) && req0) ? SERVE0 : req1 ? SERVE1 : IDLE) :
                    req0 ? ((req1 && !r_last) ? SERVE1 : SERVE0) :
                    req1 ? SERVE1 : IDLE;
    assign w_enter = (w_next != r_state) && (w_next != IDLE);
    assign w_a  = gnt1 ? a1 : a0;
    assign w_b  = gnt1 ? b1 : b0;
    assign w_op = gnt1 ? op1 : op0;
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_last  <= 1'b1;
            r_valid <= 1'b0;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= w_xfer;
            if (w_xfer) r_owner <= w_xfer1;
            if (w_enter) begin
                r_hold <= '0;
                r_last <= w_next == SERVE1;
            end else if (w_xfer && !w_cap) begin
                r_hold <= r_hold + 3'd1;
            end
        end
    end
    bm_if_op_unit #(.BITS(BITS)) u_op (
        .clock    (clock),
        .reset    (reset),
        .i_en     (w_xfer),
        .i_a      (w_a),
        .i_b      (w_b),
        .i_op     (w_op),
        .o_result (result)
    );
    assign valid = r_valid;
    assign owner = r_owner;
endmodule

// File: doc/bm_if_arbiter.md
# bm_if_arbiter

A two-requester round-robin arbiter and sequencer for a shared 2-bit logic datapath. It sits in front of a registered op unit of the same flavour as the micro benchmark datapaths. Each cycle it decides which requester owns the op unit and caps how long one requester may hold it. It then returns a registered result tagged with the owner. The block is used as the next micro regression benchmark for FSM and arbitration synthesis.

## Interface
- `BITS`, default 2: operand and result width.
- `HOLD_MAX`, default 3: maximum consecutive transfer cycles granted to one requester while the other is waiting. Legal range is 1..7.

Ports:
- `clock`, in, 1: sole clock. All state changes on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `req0`, `req1`, in, 1: request from requester 0 or 1.
- `a0`, `b0`, `a1`, `b1`, in, `BITS`: operands per requester.
- `op0`, `op1`, in, 2: opcode per requester.
  - 00 = a&b
  - 01 = a|b
  - 10 = a^b
  - 11 = case decode of a (00→11, 01→10, 10→01, 11→00)
- `gnt0`, `gnt1`, out, 1: registered grant. The two are never both 1.
- `result`, out, `BITS`: registered op-unit output.
- `valid`, out, 1: `result` holds a completed transfer.
- `owner`, out, 1: requester that produced `result`.
- `busy`, out, 1: FSM is not IDLE.

## Operation
- FSM states are IDLE, SERVE0 and SERVE1.
  - `gnt0` = (state==SERVE0).
  - `gnt1` = (state==SERVE1).
  - `busy` = (state!=IDLE).
- A transfer occurs in any cycle where `gntk` && `reqk`.
  - The operands and opcode of k are sampled at that edge.
  - `result` and `owner` = k appear the next cycle with `valid`=1.
  - `valid`=0 after any cycle with no transfer.
  - `result` and `owner` hold their last value when `valid`=0.
- Round-robin pointer `last`:
  - Records the owner of the most recent grant.
  - Reset value 1, so req0 wins the first tie.
- Transitions from IDLE:
  - One request goes to its SERVE state.
  - Both requests go to the SERVE state of the requester ≠ `last`.
  - No request stays in IDLE.
- Transitions from SERVEk:
  - If `reqk`=0: go to SERVE of the other requester if it is requesting, else IDLE.
  - If `reqk`=1 and `hold_cnt`==`HOLD_MAX`-1 and the other requester is requesting: switch to SERVE of the other requester.
  - Otherwise stay in SERVEk.
- Grant hand-over between requesters has no bubble: `gnt0` falls and `gnt1` rises on the same edge.
- `hold_cnt` (3 bits):
  - Cleared on entry to any SERVE state.
  - Increments on each transfer while staying in the same state.
  - Saturates at `HOLD_MAX`-1.
  - Meaningful only while the other requester is pending. A lone requester keeps the grant indefinitely.
- `last` updates on entry to a SERVE state.

## Timing
- req→gnt latency is 1 cycle: req rises in cycle 0, gnt is high in cycle 1.
- gnt→result latency is 1 cycle: a transfer in cycle 1 gives `valid` in cycle 2.
- Throughput is one result per cycle, including across a hand-over.
- Reset values:
  - `gnt0`=`gnt1`=0, `valid`=0, `result`=0, `owner`=0, `busy`=0.
  - state=IDLE, `hold_cnt`=0, `last`=1.
- Reset asserted mid-transfer:
  - The in-flight result is discarded.
  - All outputs show reset values in the cycle after the reset edge.
- Reset has priority over every other event.

## Structure
- Shared defines file (`bm_if_defs`) holds:
  - `BITS`
  - state encodings: IDLE=2'b00, SERVE0=2'b01, SERVE1=2'b10
  - opcode encodings
- Sub-module `bm_if_op_unit`: operand mux output, opcode and operands in; registered `result` out.
  - Its `case` decode contains an `if` on a, in the same if-collapse style as the existing benchmark.
- The top level holds the FSM, `hold_cnt`, `last`, operand mux and `valid`/`owner` pipeline registers.

## Test plan
- Reset release, no requests: all outputs 0 for 10 cycles; `busy`=0.
- `req0`=1 alone, a0=2'b11, b0=2'b01, op0=00:
  - `gnt0` in cycle 1.
  - `result`=2'b01, `owner`=0, `valid`=1 in cycle 2.
  - `gnt0` stays high for 8 cycles.
- `req0` and `req1` rise together from reset, both held, `HOLD_MAX`=3:
  - grant sequence gnt0×3, gnt1×3, gnt0×3.
  - `valid` continuous from cycle 2.
  - `owner` alternates in runs of 3.
- `op1`=11, a1=2'b01 while `req1` is granted: `result`=2'b10; then a1=2'b11 gives `result`=2'b00.
- `req0` drops while `gnt0`=1 and `req1`=1: no transfer in that cycle (`valid`=0 next cycle); `gnt1`=1 on the next edge.
- Reset asserted in a cycle with `gnt1`=1 and a transfer pending: next cycle `valid`=0, `gnt1`=0, state IDLE; first grant after release goes to `req0` on a tie.
